// File: rtl/down_count_mon_pkg.sv
// Shared types and helpers for the ripple-counter monitor.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package down_count_mon_pkg;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    localparam int MAX_W = 32;

    // Value a down counter of the given width must show after p.
    function automatic logic [MAX_W-1:0] pred_val(input logic [MAX_W-1:0] p, input int width);
        logic [MAX_W-1:0] mask;
        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        return (p - MAX_W'(1)) & mask;
    endfunction

endpackage

// File: rtl/down_count_monitor_stable_filter.sv
// Two-flop synchronizer plus a stability filter on an asynchronous bus.
// Latency: d held from edge k is presented with accept high for the edge k+2+STABLE_CYCLES.
// Backpressure: none; accept is a single-cycle strobe per settled value.
module stable_filter #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             accept
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_HIT = RUN_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [RUN_W-1:0] run;

    // Synchronize, then count how long the synchronized value has held; the
    // run starts saturated after reset so the cleared pipe is not taken as a fresh 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            run  <= RUN_MAX;
        end else begin
            s1   <= d;
            s2   <= s1;
            cand <= s2;
            if (s2 != cand) begin
                run <= '0;
            end else if (run != RUN_MAX) begin
                run <= run + RUN_W'(1);
            end
        end
    end

    assign q      = cand;
    assign accept = (s2 == cand) && (run == RUN_HIT);

endmodule

// File: rtl/down_count_monitor.sv
// Tracks a ripple down counter: accepts settled values, checks decrements, counts wraps.
// Latency: q_in held from edge k reaches q_stable at edge k+2+STABLE_CYCLES; pulses registered.
// Backpressure: none. Optional MON_PERIOD_EN adds a tc-to-tc period output.
module down_count_monitor
    import down_count_mon_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int WRAP_CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WIDTH-1:0]      q_in,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      q_stable,
    output logic                  valid,
    output logic                  tc,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic                  seq_err,
    output logic [WIDTH-1:0]      err_value
`ifdef MON_PERIOD_EN
    ,
    output logic [WRAP_CNT_W+7:0] period
`endif
);

    state_t                state;
    state_t                state_nxt;
    logic [WIDTH-1:0]      filt_q;
    logic                  accept;
    logic [WIDTH-1:0]      pred;
    logic                  changed;
    logic                  legal;
    logic [WIDTH-1:0]      qs_nxt;
    logic                  valid_nxt;
    logic                  tc_nxt;
    logic                  wrap_nxt;
    logic [WRAP_CNT_W-1:0] wc_nxt;
    logic                  err_nxt;
    logic [WIDTH-1:0]      ev_nxt;

    stable_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filt (
        .clk    (clk),
        .rst    (rst),
        .d      (q_in),
        .q      (filt_q),
        .accept (accept)
    );

    assign pred    = WIDTH'(pred_val(MAX_W'(q_stable), WIDTH));
    assign changed = accept && (filt_q != q_stable);
    assign legal   = (filt_q == pred);

    // Next state and next output values; a new error outranks a same-cycle clear.
    always_comb begin
        state_nxt = state;
        qs_nxt    = q_stable;
        valid_nxt = valid;
        tc_nxt    = 1'b0;
        wrap_nxt  = 1'b0;
        wc_nxt    = wrap_count;
        err_nxt   = seq_err;
        ev_nxt    = err_value;
        if (!en) begin
            state_nxt = S_INIT;
            valid_nxt = 1'b0;
        end else begin
            if (clr_err) begin
                err_nxt = 1'b0;
            end
            case (state)
                S_INIT: begin
                    if (accept) begin
                        qs_nxt    = filt_q;
                        valid_nxt = 1'b1;
                    end
                end
                S_TRACK, S_ERR: begin
                    if (changed) begin
                        qs_nxt = filt_q;
                        if (legal) begin
                            tc_nxt = (filt_q == '0);
                            if (q_stable == '0) begin
                                wrap_nxt = 1'b1;
                                if (wrap_count != '1) begin
                                    wc_nxt = wrap_count + 1'b1;
                                end
                            end
                        end else begin
                            err_nxt = 1'b1;
                            if (!seq_err || clr_err) begin
                                ev_nxt = filt_q;
                            end
                        end
                    end
                end
                default: ;
            endcase
            if (state != S_INIT || accept) begin
                state_nxt = err_nxt ? S_ERR : S_TRACK;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            q_stable   <= '0;
            valid      <= 1'b0;
            tc         <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            seq_err    <= 1'b0;
            err_value  <= '0;
        end else begin
            state      <= state_nxt;
            q_stable   <= qs_nxt;
            valid      <= valid_nxt;
            tc         <= tc_nxt;
            wrap_pulse <= wrap_nxt;
            wrap_count <= wc_nxt;
            seq_err    <= err_nxt;
            err_value  <= ev_nxt;
        end
    end

`ifdef MON_PERIOD_EN
    logic [WRAP_CNT_W+7:0] per_cnt;
    logic                  per_run;

    // Cycles between tc events; per_cnt holds the distance to the last tc.
    always_ff @(posedge clk) begin
        if (rst || !en || state == S_INIT) begin
            per_cnt <= '0;
            per_run <= 1'b0;
            period  <= '0;
        end else if (tc_nxt) begin
            if (per_run) begin
                period <= per_cnt;
            end
            per_cnt <= (WRAP_CNT_W + 8)'(1);
            per_run <= 1'b1;
        end else if (per_run && per_cnt != '1) begin
            per_cnt <= per_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_down_count_monitor.sv
// Bench for down_count_monitor: directed stimulus, per-cycle model compare, literal pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_down_count_monitor;

    localparam int W   = 2;
    localparam int S   = 2;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] q_in;
    logic         clr_err;

    logic [W-1:0] q_stable;
    logic         valid;
    logic         tc;
    logic         wrap_pulse;
    logic [7:0]   wrap_count;
    logic         seq_err;
    logic [W-1:0] err_value;

    logic [W-1:0] q_stable_s;
    logic         valid_s;
    logic         tc_s;
    logic         wrap_pulse_s;
    logic [1:0]   wrap_count_s;
    logic         seq_err_s;
    logic [W-1:0] err_value_s;
`ifdef MON_PERIOD_EN
    logic [15:0]  period;
    logic [9:0]   period_s;
`endif

    int checks   = 0;
    int failures = 0;
    int n_tc     = 0;
    int n_wp     = 0;

    down_count_monitor #(.WIDTH(W), .STABLE_CYCLES(S), .WRAP_CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .q_in       (q_in),
        .clr_err    (clr_err),
        .q_stable   (q_stable),
        .valid      (valid),
        .tc         (tc),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .seq_err    (seq_err),
        .err_value  (err_value)
`ifdef MON_PERIOD_EN
        ,
        .period     (period)
`endif
    );

    down_count_monitor #(.WIDTH(W), .STABLE_CYCLES(S), .WRAP_CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .q_in       (q_in),
        .clr_err    (clr_err),
        .q_stable   (q_stable_s),
        .valid      (valid_s),
        .tc         (tc_s),
        .wrap_pulse (wrap_pulse_s),
        .wrap_count (wrap_count_s),
        .seq_err    (seq_err_s),
        .err_value  (err_value_s)
`ifdef MON_PERIOD_EN
        ,
        .period     (period_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: a value is accepted when the run of identical raw samples ending
    // two edges back is exactly S+1 long; then the decrement rules apply.
    int m_hist[$];
    int m_qs, m_valid, m_tc, m_wp, m_wc, m_wcs, m_err, m_ev;
    bit m_live = 1'b0;

    always @(posedge clk) begin : model
        int v;
        int len;
        bit acc;
        bit newerr;
        if (rst) begin
            m_hist.delete();
            for (int i = 0; i < S + 3; i++) m_hist.push_back(0);
            m_qs = 0; m_valid = 0; m_tc = 0; m_wp = 0;
            m_wc = 0; m_wcs = 0; m_err = 0; m_ev = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            v   = m_hist[m_hist.size() - 2];
            len = 0;
            for (int i = m_hist.size() - 2; i >= 0; i--) begin
                if (m_hist[i] != v) break;
                len++;
            end
            acc = (len == S + 1);
            m_hist.push_back(int'(q_in));
            if (m_hist.size() > 12) void'(m_hist.pop_front());
            m_tc   = 0;
            m_wp   = 0;
            newerr = 1'b0;
            if (!en) begin
                m_valid = 0;
            end else begin
                if (acc && m_valid == 0) begin
                    m_qs    = v;
                    m_valid = 1;
                end else if (acc && v != m_qs) begin
                    if (v == (m_qs + MOD - 1) % MOD) begin
                        if (v == 0) m_tc = 1;
                        if (m_qs == 0) begin
                            m_wp = 1;
                            if (m_wc < 255) m_wc++;
                            if (m_wcs < 3) m_wcs++;
                        end
                    end else begin
                        newerr = 1'b1;
                    end
                    m_qs = v;
                end
                if (newerr) begin
                    if (m_err == 0 || clr_err) m_ev = v;
                    m_err = 1;
                end else if (clr_err) begin
                    m_err = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc_q_stable",   32'(q_stable),     m_qs);
            chk("cyc_valid",      32'(valid),        m_valid);
            chk("cyc_tc",         32'(tc),           m_tc);
            chk("cyc_wrap_pulse", 32'(wrap_pulse),   m_wp);
            chk("cyc_wrap_count", 32'(wrap_count),   m_wc);
            chk("cyc_wrap_sat",   32'(wrap_count_s), m_wcs);
            chk("cyc_seq_err",    32'(seq_err),      m_err);
            chk("cyc_err_value",  32'(err_value),    m_ev);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (tc) n_tc++;
        if (wrap_pulse) n_wp++;
    endtask

    task automatic hold(input int v, input int n);
        q_in = W'(v);
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; q_in = 2'd3; clr_err = 1'b0;

        // Reset
        repeat (3) tick();
        chk("rst_q_stable",   32'(q_stable),   0);
        chk("rst_valid",      32'(valid),      0);
        chk("rst_tc",         32'(tc),         0);
        chk("rst_wrap_count", 32'(wrap_count), 0);
        chk("rst_seq_err",    32'(seq_err),    0);
        chk("rst_err_value",  32'(err_value),  0);
        rst = 1'b0; en = 1'b1;
        repeat (4) tick();
        chk("lat_valid_early", 32'(valid), 0);
        tick();
        chk("lat_valid",    32'(valid),    1);
        chk("lat_q_stable", 32'(q_stable), 3);

        // Normal down sequence through one wrap
        n_tc = 0; n_wp = 0;
        hold(3, 5); hold(2, 10); hold(1, 10); hold(0, 10); hold(3, 10); hold(2, 10);
        chk("norm_tc_count",   n_tc, 1);
        chk("norm_wrap_count", n_wp, 1);
        chk("norm_wrap_reg",   32'(wrap_count), 1);
        chk("norm_seq_err",    32'(seq_err),    0);
        chk("norm_q_stable",   32'(q_stable),   2);

        // One-cycle glitch is filtered
        n_tc = 0;
        hold(0, 1); hold(1, 10);
        chk("glitch_q_stable", 32'(q_stable), 1);
        chk("glitch_seq_err",  32'(seq_err),  0);
        chk("glitch_tc",       n_tc, 0);

        // Skipped value 3 -> 1, then a legal 1 -> 0 still pulses tc
        hold(0, 10); hold(3, 10); hold(1, 10);
        chk("skip_seq_err",   32'(seq_err),   1);
        chk("skip_err_value", 32'(err_value), 1);
        n_tc = 0;
        hold(0, 10);
        chk("skip_tc_after",  n_tc, 1);
        chk("skip_err_hold",  32'(err_value), 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0; tick();
        chk("skip_cleared",   32'(seq_err), 0);

        // Clear coinciding with a new illegal acceptance
        hold(2, 10);
        chk("sim_first_err", 32'(err_value), 2);
        q_in = 2'd0;
        repeat (4) tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("sim_seq_err",   32'(seq_err),   1);
        chk("sim_err_value", 32'(err_value), 0);
        chk("sim_q_stable",  32'(q_stable),  0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;

        // Enable low: hold outputs, re-enter as a fresh first value
        en = 1'b0;
        hold(2, 8);
        chk("en_valid",    32'(valid),    0);
        chk("en_q_hold",   32'(q_stable), 0);
        en = 1'b1;
        hold(2, 4);
        chk("en_no_accept", 32'(valid), 0);
        hold(1, 10);
        chk("en_reload",   32'(q_stable), 1);
        chk("en_no_err",   32'(seq_err),  0);

        // Five full down cycles: wide counter counts, narrow one saturates
        for (int c = 0; c < 5; c++) begin
            hold(0, 6); hold(3, 6); hold(2, 6); hold(1, 6);
        end
        chk("sat_wide",   32'(wrap_count),   7);
        chk("sat_narrow", 32'(wrap_count_s), 3);

        // Reset in the middle of tracking with an error pending
        hold(3, 10);
        chk("mid_err_set", 32'(seq_err), 1);
        hold(2, 2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_err",   32'(seq_err),    0);
        chk("mid_rst_wrap",  32'(wrap_count), 0);
        chk("mid_rst_valid", 32'(valid),      0);
        n_tc = 0;
        hold(1, 10);
        chk("mid_valid",    32'(valid),    1);
        chk("mid_q_stable", 32'(q_stable), 1);
        chk("mid_no_err",   32'(seq_err),  0);
        chk("mid_no_tc",    n_tc, 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
